// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction fetch unit and its timer.
//   WORD_W        instruction / address width
//   ALIGN_MASK    low address bits that must be zero for a word fetch
//   TIMER_W       width of the memory-wait timer
//   fetch_state_e fetch FSM state encoding
//   is_misaligned word-alignment test on the low address bits
package mips_pkg;

    localparam int         WORD_W     = 32;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int         TIMER_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUSY  = 3'd1,
        ST_VALID = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: saturating wait counter for memory requests.
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   clr_i      synchronous clear (wins over enable)
//   en_i       count one more cycle
//   expired_o  high while the count equals TIMEOUT-1, i.e. on the last
//              allowed wait cycle
module fetch_timer
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LIMIT   = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SAT_MAX = '1;

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != SAT_MAX)) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: takes the PC address, reads the instruction memory with
// a req/ack handshake and hands the instruction to decode (valid/ready).
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   pc, pc_valid      fetch request from the PC register
//   flush             redirect: abandon the current fetch
//   pc_stall          PC must hold (address not accepted this cycle)
//   mem_req/mem_addr  memory read request, held until mem_ack
//   mem_ack/mem_rdata one-cycle read completion with data
//   instr/instr_pc    fetched instruction and its address
//   instr_valid/ready handshake to decode
//   fetch_err         misaligned address or memory timeout, held until flush
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              pc_stall,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_err
);

    fetch_state_e      state_q;
    logic              mem_req_q;
    logic [WORD_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] instr_pc_q;
    logic              instr_valid_q;
    logic              fetch_err_q;

    logic accept_ok;
    logic enter_drain;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    // Timer restarts on every entry to BUSY or DRAIN, so a drain gets its
    // own full TIMEOUT window.
    assign accept_ok   = (state_q == ST_IDLE) && pc_valid && !flush
                         && !is_misaligned(pc[1:0]);
    assign enter_drain = (state_q == ST_BUSY) && flush && !mem_ack;
    assign timer_clr   = accept_ok || enter_drain;
    assign timer_en    = ((state_q == ST_BUSY) || (state_q == ST_DRAIN)) && !mem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clock),
        .rst_ni    (reset),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pc_valid && !flush) begin
                        if (is_misaligned(pc[1:0])) begin
                            state_q     <= ST_ERR;
                            fetch_err_q <= 1'b1;
                        end else begin
                            state_q    <= ST_BUSY;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        // An ack coinciding with flush completes the read
                        // but its data belongs to the abandoned path.
                        if (flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q       <= ST_VALID;
                            instr_q       <= mem_rdata;
                            instr_pc_q    <= mem_addr_q;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (flush) begin
                        // Request stays up at the same address until the
                        // memory answers; the answer is then thrown away.
                        state_q <= ST_DRAIN;
                    end else if (timer_expired) begin
                        state_q     <= ST_ERR;
                        mem_req_q   <= 1'b0;
                        fetch_err_q <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (flush || instr_ready) begin
                        state_q       <= ST_IDLE;
                        instr_valid_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack || timer_expired) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (flush) begin
                        state_q     <= ST_IDLE;
                        fetch_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    fetch_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pc_stall    = (state_q != ST_IDLE);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: bench for instr_fetch_unit. Vector table, hand-written
// multi-cycle sequences, and random traffic against a reference model.
module tb_instr_fetch_unit;

    localparam int TO_FAST = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        flush = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_ready = 1'b0;

    logic        pc_stall, mem_req, instr_valid, fetch_err;
    logic [31:0] mem_addr, instr, instr_pc;
    logic        s_pc_stall, s_mem_req, s_instr_valid, s_fetch_err;
    logic [31:0] s_mem_addr, s_instr, s_instr_pc;

    always #5 clock = ~clock;

    instr_fetch_unit #(.TIMEOUT(TO_FAST)) u_dut (
        .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .pc_stall(pc_stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .fetch_err(fetch_err)
    );

    // Long-timeout instance for the slow-memory sequence.
    instr_fetch_unit #(.TIMEOUT(255)) u_slow (
        .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .pc_stall(s_pc_stall), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(s_instr), .instr_pc(s_instr_pc),
        .instr_valid(s_instr_valid), .instr_ready(instr_ready), .fetch_err(s_fetch_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_vld, input logic [31:0] e_instr,
                           input logic [31:0] e_ipc, input logic e_err, input logic e_stall);
        chk({tag, ".mem_req"},     {31'b0, mem_req},     {31'b0, e_req});
        chk({tag, ".mem_addr"},    mem_addr,             e_addr);
        chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, e_vld});
        chk({tag, ".instr"},       instr,                e_instr);
        chk({tag, ".instr_pc"},    instr_pc,             e_ipc);
        chk({tag, ".fetch_err"},   {31'b0, fetch_err},   {31'b0, e_err});
        chk({tag, ".pc_stall"},    {31'b0, pc_stall},    {31'b0, e_stall});
    endtask

    task automatic idle_inputs();
        pc_valid = 1'b0; pc = '0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    // Reference model: a fetch is "outstanding" while a request is up,
    // req_cycles counts completed request cycles for the current wait.
    bit          m_req, m_valid, m_err, m_drain;
    logic [31:0] m_addr, m_instr, m_ipc;
    int          m_req_cycles;

    task automatic model_reset();
        m_req = 0; m_valid = 0; m_err = 0; m_drain = 0;
        m_addr = '0; m_instr = '0; m_ipc = '0; m_req_cycles = 0;
    endtask

    task automatic model_step();
        if (m_err) begin
            if (flush) m_err = 0;
        end else if (m_valid) begin
            if (flush || instr_ready) m_valid = 0;
        end else if (m_req) begin
            m_req_cycles++;
            if (m_drain) begin
                if (mem_ack || m_req_cycles == TO_FAST) begin
                    m_req = 0; m_drain = 0;
                end
            end else if (mem_ack) begin
                m_req = 0; m_valid = 1; m_instr = mem_rdata; m_ipc = m_addr;
            end else if (flush) begin
                m_drain = 1; m_req_cycles = 0;
            end else if (m_req_cycles == TO_FAST) begin
                m_req = 0; m_err = 1;
            end
        end else if (pc_valid && !flush) begin
            if (pc % 4 != 0) begin
                m_err = 1;
            end else begin
                m_req = 1; m_addr = pc; m_req_cycles = 0;
            end
        end
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        fl;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_err;
        logic        e_stall;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        pv  pc            fl  ack rdata          rdy req addr          vld instr          ipc           err stall
        tbl[0]  = '{1, 32'h10,       0, 0, 32'h0,          0,  1, 32'h10,       0, 32'h0,         32'h0,   0, 1};
        tbl[1]  = '{0, 32'h0,        0, 1, 32'h2008_0005,  1,  0, 32'h10,       1, 32'h2008_0005, 32'h10,  0, 1};
        tbl[2]  = '{0, 32'h0,        0, 0, 32'h0,          1,  0, 32'h10,       0, 32'h2008_0005, 32'h10,  0, 0};
        tbl[3]  = '{1, 32'h6,        0, 0, 32'h0,          0,  0, 32'h10,       0, 32'h2008_0005, 32'h10,  1, 1};
        tbl[4]  = '{1, 32'h6,        0, 0, 32'h0,          0,  0, 32'h10,       0, 32'h2008_0005, 32'h10,  1, 1};
        tbl[5]  = '{0, 32'h0,        1, 0, 32'h0,          0,  0, 32'h10,       0, 32'h2008_0005, 32'h10,  0, 0};
        tbl[6]  = '{1, 32'h100,      0, 0, 32'h0,          0,  1, 32'h100,      0, 32'h2008_0005, 32'h10,  0, 1};
        tbl[7]  = '{0, 32'h0,        0, 0, 32'h0,          0,  1, 32'h100,      0, 32'h2008_0005, 32'h10,  0, 1};
        tbl[8]  = '{0, 32'h0,        0, 0, 32'h0,          0,  1, 32'h100,      0, 32'h2008_0005, 32'h10,  0, 1};
        tbl[9]  = '{0, 32'h0,        0, 0, 32'h0,          0,  1, 32'h100,      0, 32'h2008_0005, 32'h10,  0, 1};
        tbl[10] = '{0, 32'h0,        0, 0, 32'h0,          0,  0, 32'h100,      0, 32'h2008_0005, 32'h10,  1, 1};
        tbl[11] = '{0, 32'h0,        0, 1, 32'hFFFF_FFFF,  0,  0, 32'h100,      0, 32'h2008_0005, 32'h10,  1, 1};
        tbl[12] = '{0, 32'h0,        1, 0, 32'h0,          0,  0, 32'h100,      0, 32'h2008_0005, 32'h10,  0, 0};
        tbl[13] = '{1, 32'h40,       1, 0, 32'h0,          0,  0, 32'h100,      0, 32'h2008_0005, 32'h10,  0, 0};

        // Reset values while reset is held low.
        idle_inputs();
        reset = 1'b0;
        step();
        chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // Vector table: zero-wait fetch, misaligned, timeout, flush in IDLE.
        for (int i = 0; i < 14; i++) begin
            pc_valid = tbl[i].pv; pc = tbl[i].pc; flush = tbl[i].fl;
            mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata; instr_ready = tbl[i].rdy;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                    tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_err, tbl[i].e_stall);
        end

        // Slow memory (ack after 5 wait cycles), decode stalls 3 cycles.
        do_reset();
        pc_valid = 1; pc = 32'h30;
        step();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("slow.req%0d", i),   {31'b0, s_mem_req},     32'h1);
            chk($sformatf("slow.addr%0d", i),  s_mem_addr,             32'h30);
            chk($sformatf("slow.stall%0d", i), {31'b0, s_pc_stall},    32'h1);
            chk($sformatf("slow.vld%0d", i),   {31'b0, s_instr_valid}, 32'h0);
            step();
        end
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("slow.hold_vld%0d", i),   {31'b0, s_instr_valid}, 32'h1);
            chk($sformatf("slow.hold_instr%0d", i), s_instr,                32'h1234_5678);
            chk($sformatf("slow.hold_ipc%0d", i),   s_instr_pc,             32'h30);
            chk($sformatf("slow.hold_stall%0d", i), {31'b0, s_pc_stall},    32'h1);
            chk($sformatf("slow.hold_req%0d", i),   {31'b0, s_mem_req},     32'h0);
            step();
        end
        instr_ready = 1;
        step();
        instr_ready = 0;
        chk("slow.xfer_vld",   {31'b0, s_instr_valid}, 32'h0);
        chk("slow.xfer_stall", {31'b0, s_pc_stall},    32'h0);
        chk("slow.xfer_instr", s_instr,                32'h1234_5678);
        chk("slow.err",        {31'b0, s_fetch_err},   32'h0);

        // Flush during BUSY; the late ack must be swallowed.
        do_reset();
        pc_valid = 1; pc = 32'h20;
        step();
        idle_inputs();
        chk_all("fl.busy", 1, 32'h20, 0, 32'h0, 32'h0, 0, 1);
        flush = 1;
        step();
        flush = 0;
        chk_all("fl.drain", 1, 32'h20, 0, 32'h0, 32'h0, 0, 1);
        step();
        chk_all("fl.drain2", 1, 32'h20, 0, 32'h0, 32'h0, 0, 1);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        chk_all("fl.idle", 0, 32'h20, 0, 32'h0, 32'h0, 0, 0);
        step();
        chk_all("fl.still_idle", 0, 32'h20, 0, 32'h0, 32'h0, 0, 0);
        pc_valid = 1; pc = 32'h80;
        step();
        pc_valid = 0;
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        step();
        idle_inputs();
        chk_all("fl.next", 0, 32'h80, 1, 32'h1111_2222, 32'h80, 0, 1);

        // Reset asserted in the middle of a BUSY cycle.
        do_reset();
        pc_valid = 1; pc = 32'h40;
        step();
        idle_inputs();
        chk("rst.busy_req", {31'b0, mem_req}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_all("rst.async", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk_all("rst.released", 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        pc_valid = 1; pc = 32'h44;
        step();
        idle_inputs();
        chk_all("rst.reaccept", 1, 32'h44, 0, 32'h0, 32'h0, 0, 1);

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 800; n++) begin
            pc_valid = ($urandom_range(0, 1) == 1);
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            flush = ($urandom_range(0, 9) == 0);
            mem_ack = !flush && ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            instr_ready = ($urandom_range(0, 1) == 1);
            @(posedge clock);
            model_step();
            #1;
            chk_all($sformatf("rnd%0d", n), m_req, m_addr, m_valid, m_instr, m_ipc, m_err,
                    m_req | m_valid | m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
